memory_arbiter: RTL

Sequences the single shared RAM port between the instruction cache and the data cache. Latches a grant per transaction, drives RAM read/write strobes for the owner, returns data and `wait` handshakes to each cache, and prevents dcache-priority from starving instruction fetch. Sits between icache/dcache miss paths and the RAM model/bus.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/memory_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: bus word, RAM handshake state and arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE,
    IGRANT,
    DGRANT
  } arb_state_t;

endpackage

// File: rtl/memory_arbiter.sv
// Arbitrates the single RAM port between icache and dcache, granting one
// transaction at a time with dcache priority bounded by a starvation limit.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  arb_state_t    state, state_next;
  logic [SW-1:0] streak, streak_next;
  ramstate_t     rs;
  logic          dreq;
  logic          ram_done;

  assign rs       = ramstate_t'(ramstate);
  assign dreq     = dREN | dWEN;
  assign ram_done = (rs == ACCESS);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_next;
      streak <= streak_next;
    end
  end

  always_comb begin
    state_next  = state;
    streak_next = streak;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    iload       = '0;
    dload       = '0;
    iwait       = 1'b1;
    dwait       = 1'b1;

    unique case (state)
      IDLE: begin
        // dcache wins ties until it has starved a waiting icache LIMIT times
        if (dreq && !(iREN && streak == LIMIT))
          state_next = DGRANT;
        else if (iREN)
          state_next = IGRANT;
      end

      IGRANT: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iload   = ramload;
        if (!iREN) begin
          state_next = IDLE;
        end else if (ram_done) begin
          iwait       = 1'b0;
          state_next  = IDLE;
          streak_next = '0;
        end
      end

      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramstore = dWEN ? dstore : '0;
        ramaddr  = daddr;
        dload    = ramload;
        if (!dreq) begin
          state_next = IDLE;
        end else if (ram_done) begin
          dwait      = 1'b0;
          state_next = IDLE;
          if (iREN)
            streak_next = (streak == LIMIT) ? streak : streak + 1'b1;
          else
            streak_next = '0;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
